// File: rtl/vector_db_responder.sv
// vector_db_responder: fixed-latency read responder serving a 4-word header plus beat storage.
// Optional statistics counters are enabled by defining VECTOR_DB_RESPONDER_STATS_EN.
module vector_db_responder #(
    parameter int BUS_WIDTH    = 512,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_rd_en,
    input  logic [31:0]              mem_rd_addr,
    output logic [BUS_WIDTH-1:0]     mem_rd_data,
    output logic                     mem_rd_valid,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_beat,
    input  logic [BUS_WIDTH-1:0]     wr_data,
    input  logic                     load_hdr,
    input  logic [31:0]              cfg_db_size,
    input  logic [31:0]              cfg_db_addr_start,
    input  logic [31:0]              cfg_vector_stride,
    input  logic [31:0]              cfg_meta_addr_start,
    input  logic                     clr_err,
    output logic                     err_misalign,
    output logic                     err_oob,
    output logic                     busy
`ifdef VECTOR_DB_RESPONDER_STATS_EN
    ,
    output logic [31:0]              stat_beats,
    output logic [15:0]              stat_errs
`endif
);
    localparam int          OFF_W   = $clog2(BUS_WIDTH / 8);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);
    localparam logic [3:0]  LAT_M1  = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0][31:0]      hdr_q, hdr_d;
    logic [31:0]           word_q, word_d;
    logic                  use_mem_q, use_mem_d;
    logic [BUS_WIDTH-1:0]  hold_q, hold_d;
    logic                  err_mis_q, err_mis_d;
    logic                  err_oob_q, err_oob_d;
    logic [BUS_WIDTH-1:0]  mem_q [DEPTH];
    logic [BUS_WIDTH-1:0]  ram_rd_q;
    logic [BUS_WIDTH-1:0]  live;
    logic [31:0]           beat;
    logic                  accept;
    logic                  mis;
    logic                  oob;

    assign beat = mem_rd_addr >> OFF_W;
    assign mis  = |mem_rd_addr[OFF_W-1:0];
    assign oob  = beat >= DEPTH_L;

    // Request FSM: accept in IDLE, count out the latency in WAIT, pulse valid in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_rd_en) begin
                    accept  = 1'b1;
                    state_d = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                state_d = !mem_rd_en ? S_IDLE : (cnt_q <= 4'd1) ? S_RESP : S_WAIT;
                cnt_d   = (!mem_rd_en || cnt_q <= 4'd1) ? 4'd0 : cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response datapath: the source is resolved at acceptance so later header loads or
    // storage writes cannot disturb a read in flight; errors are sticky with set winning.
    always_comb begin
        hdr_d     = load_hdr ? {cfg_meta_addr_start, cfg_vector_stride, cfg_db_addr_start, cfg_db_size} : hdr_q;
        word_d    = !accept ? word_q : (mis || oob || beat >= 32'd4) ? 32'd0 : hdr_q[beat[1:0]];
        use_mem_d = accept ? (!mis && !oob && beat >= 32'd4) : use_mem_q;
        live      = use_mem_q ? ram_rd_q : {{(BUS_WIDTH-32){1'b0}}, word_q};
        hold_d    = (state_q == S_RESP) ? live : hold_q;
        err_mis_d = (accept && mis) || (err_mis_q && !clr_err);
        err_oob_d = (accept && oob) || (err_oob_q && !clr_err);
    end

    // Storage array: never reset; the read port samples at acceptance so a same-cycle
    // write to the same beat returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_beat] <= wr_data;
        if (accept) ram_rd_q <= mem_q[beat[AW-1:0]];
    end

    // Control and header state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hdr_q     <= '0;
            word_q    <= '0;
            use_mem_q <= 1'b0;
            hold_q    <= '0;
            err_mis_q <= 1'b0;
            err_oob_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            word_q    <= word_d;
            use_mem_q <= use_mem_d;
            hold_q    <= hold_d;
            err_mis_q <= err_mis_d;
            err_oob_q <= err_oob_d;
        end
    end

    assign mem_rd_valid = (state_q == S_RESP);
    assign mem_rd_data  = (state_q == S_RESP) ? live : hold_q;
    assign busy         = (state_q != S_IDLE);
    assign err_misalign = err_mis_q;
    assign err_oob      = err_oob_q;

`ifdef VECTOR_DB_RESPONDER_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    // Saturating beat and error counters, cleared together with the error flags.
    always_comb begin
        stat_beats_d = clr_err ? 32'd0 : (state_q == S_RESP && stat_beats_q != '1) ? stat_beats_q + 32'd1 : stat_beats_q;
        stat_errs_d  = clr_err ? 16'd0 : (accept && (mis || oob) && stat_errs_q != '1) ? stat_errs_q + 16'd1 : stat_errs_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats_q <= '0;
            stat_errs_q  <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_errs_q  <= stat_errs_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_errs  = stat_errs_q;
`endif
endmodule

// File: tb/tb_vector_db_responder.sv
// tb_vector_db_responder: scoreboard bench for vector_db_responder with directed vectors.
module tb_vector_db_responder;
    localparam int BW    = 512;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              mem_rd_en = 1'b0;
    logic [31:0]       mem_rd_addr = '0;
    logic [BW-1:0]     mem_rd_data;
    logic              mem_rd_valid;
    logic              wr_en = 1'b0;
    logic [9:0]        wr_beat = '0;
    logic [BW-1:0]     wr_data = '0;
    logic              load_hdr = 1'b0;
    logic [31:0]       cfg_db_size = '0, cfg_db_addr_start = '0, cfg_vector_stride = '0, cfg_meta_addr_start = '0;
    logic              clr_err = 1'b0;
    logic              err_misalign, err_oob, busy;
`ifdef VECTOR_DB_RESPONDER_STATS_EN
    logic [31:0]       stat_beats;
    logic [15:0]       stat_errs;
`endif

    vector_db_responder #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .READ_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .wr_en(wr_en), .wr_beat(wr_beat), .wr_data(wr_data),
        .load_hdr(load_hdr), .cfg_db_size(cfg_db_size), .cfg_db_addr_start(cfg_db_addr_start),
        .cfg_vector_stride(cfg_vector_stride), .cfg_meta_addr_start(cfg_meta_addr_start),
        .clr_err(clr_err), .err_misalign(err_misalign), .err_oob(err_oob), .busy(busy)
`ifdef VECTOR_DB_RESPONDER_STATS_EN
        , .stat_beats(stat_beats), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BW-1:0] d;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] pat, pat2;

    task automatic chk(input string n, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation in data and cycle.
    always @(negedge clk) begin
        if (mem_rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d data=%0h", cyc, mem_rd_data);
            end else begin
                e = sb.pop_front();
                if (mem_rd_data !== e.d || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_data cyc=%0d due=%0d got %0h expected %0h", cyc, e.due, mem_rd_data, e.d);
                end
            end
        end
    end

    // Single read; optionally a same-cycle write of pat2 to beat 10, a coincident clr_err,
    // or a header load while the read waits.
    task automatic rd(input logic [31:0] a, input logic [BW-1:0] exp, input bit w, input bit c, input bit h);
        mem_rd_en   = 1'b1;
        mem_rd_addr = a;
        sb.push_back('{exp, cyc + 2});
        if (w) begin
            wr_en   = 1'b1;
            wr_beat = 10'd10;
            wr_data = pat2;
        end
        clr_err = c;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        clr_err = 1'b0;
        if (h) begin
            load_hdr    = 1'b1;
            cfg_db_size = 32'd7;
        end
        @(posedge clk); #1;
        load_hdr  = 1'b0;
        mem_rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            pat[i*32 +: 32]  = 32'hA5A5_0000 + 32'(i);
            pat2[i*32 +: 32] = 32'h5A5A_0000 + 32'(i);
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", BW'(mem_rd_valid), 0);
        chk("rst_busy", BW'(busy), 0);
        chk("rst_data", mem_rd_data, 0);
        chk("rst_err_mis", BW'(err_misalign), 0);
        chk("rst_err_oob", BW'(err_oob), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_hdr = 1'b1;
        cfg_db_size = 32'd100;
        cfg_db_addr_start = 32'h400;
        cfg_vector_stride = 32'h600;
        cfg_meta_addr_start = 32'h2_0000;
        @(posedge clk); #1;
        load_hdr = 1'b0;

        mem_rd_en   = 1'b1;
        mem_rd_addr = 32'd0;
        sb.push_back('{BW'(100), cyc + 2});
        sb.push_back('{BW'(32'h400), cyc + 5});
        sb.push_back('{BW'(32'h600), cyc + 8});
        sb.push_back('{BW'(32'h2_0000), cyc + 11});
        for (int k = 0; k < 4; k++) begin
            int j;
            for (j = 0; j < 20; j++) begin
                @(negedge clk);
                if (mem_rd_valid === 1'b1) break;
            end
            if (j == 20) begin
                checks++;
                errors++;
                $display("FAIL stream_timeout: beat %0d got no valid, required valid", k);
            end
            mem_rd_addr = mem_rd_addr + 32'd64;
            if (k == 3) mem_rd_en = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        wr_en   = 1'b1;
        wr_beat = 10'd10;
        wr_data = pat;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd(32'd640, pat, 0, 0, 0);
        rd(32'd640, pat, 1, 0, 0);
        rd(32'd640, pat2, 0, 0, 0);

        rd(32'd0, BW'(100), 0, 0, 1);
        rd(32'd0, BW'(7), 0, 0, 0);

        rd(32'h41, '0, 0, 0, 0);
        chk("misalign_set", BW'(err_misalign), 1);
        chk("misalign_no_oob", BW'(err_oob), 0);
        rd(32'(DEPTH * 64), '0, 0, 0, 0);
        chk("oob_set", BW'(err_oob), 1);
        chk("misalign_sticky", BW'(err_misalign), 1);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk("clr_mis", BW'(err_misalign), 0);
        chk("clr_oob", BW'(err_oob), 0);
        rd(32'h41, '0, 0, 1, 0);
        chk("set_beats_clr", BW'(err_misalign), 1);

        mem_rd_en   = 1'b1;
        mem_rd_addr = 32'd640;
        @(posedge clk); #1;
        mem_rd_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", BW'(busy), 0);
        repeat (3) @(posedge clk);
        #1;

        mem_rd_en   = 1'b1;
        mem_rd_addr = 32'd0;
        @(posedge clk); #1;
        chk("wait_busy", BW'(busy), 1);
        rst_n = 1'b0;
        #1;
        mem_rd_en = 1'b0;
        chk("mid_rst_valid", BW'(mem_rd_valid), 0);
        chk("mid_rst_busy", BW'(busy), 0);
        chk("mid_rst_data", mem_rd_data, 0);
        chk("mid_rst_err", BW'({err_misalign, err_oob}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(32'd0, '0, 0, 0, 0);
        rd(32'd64, '0, 0, 0, 0);
        rd(32'd640, pat2, 0, 0, 0);
        rd(32'd128, '0, 0, 0, 0);
        rd(32'd192, '0, 0, 0, 0);
        rd(32'h41, '0, 0, 0, 0);
        rd(32'(DEPTH * 64), '0, 0, 0, 0);
`ifdef VECTOR_DB_RESPONDER_STATS_EN
        chk("stat_beats", BW'(stat_beats), 7);
        chk("stat_errs", BW'(stat_errs), 2);
`endif
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", BW'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_db_responder.md
VECTOR_DB_RESPONDER -- requirements
Module: vector_db_responder

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 512, read data beat width in bits (multiple of 32, ≥128).
REQ-002 SHALL have parameter DEPTH, default 1024, number of BUS_WIDTH-bit storage beats.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from request acceptance to data valid (range 1..15).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_rd_en  input  1  read request, held high by initiator while beats are wanted.
REQ-007 SHALL have port mem_rd_addr  input  32  byte address of requested beat.
REQ-008 SHALL have port mem_rd_data  output  BUS_WIDTH  returned beat.
REQ-009 SHALL have port mem_rd_valid  output  1  one-cycle pulse qualifying mem_rd_data.
REQ-010 SHALL have ports wr_en  input  1, wr_beat  input  $clog2(DEPTH), wr_data  input  BUS_WIDTH  storage load port.
REQ-011 SHALL have ports load_hdr  input  1 and cfg_db_size, cfg_db_addr_start, cfg_vector_stride, cfg_meta_addr_start  input  32 each  header load.
REQ-012 SHALL have ports clr_err  input  1; err_misalign  output  1; err_oob  output  1; busy  output  1.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; busy = (state != IDLE).
REQ-014 SHALL, in IDLE with mem_rd_en=1, accept: latch beat = mem_rd_addr / (BUS_WIDTH/8), latch data, enter WAIT with counter = READ_LATENCY-1.
REQ-015 SHALL decrement counter in WAIT; on counter=0 (or immediately when READ_LATENCY=1) enter RESP.
REQ-016 SHALL assert mem_rd_valid for exactly the RESP cycle (acceptance at cycle T -> valid in cycle T+READ_LATENCY), then return to IDLE; earliest next acceptance T+READ_LATENCY+1.
REQ-017 SHALL, if mem_rd_en falls during WAIT, abort to IDLE with no valid pulse; mem_rd_en low in RESP does not suppress the pulse.
REQ-018 SHALL serve beats 0..3 from header registers db_size, db_addr_start, vector_stride, meta_addr_start in bits [31:0], upper bits zero.
REQ-019 SHALL serve beats 4..DEPTH-1 from storage; storage beats 0..3 are never read.
REQ-020 SHALL, for mem_rd_addr not multiple of BUS_WIDTH/8, return all-zero data with normal timing and set sticky err_misalign.
REQ-021 SHALL, for beat ≥ DEPTH, return all-zero data with normal timing and set sticky err_oob.
REQ-022 SHALL sample data at acceptance; a same-cycle wr_en to the same beat yields old data (read-before-write).
REQ-023 SHALL latch all four cfg_* inputs into header registers on load_hdr=1; load_hdr during WAIT does not change latched data.
REQ-024 SHALL give set priority over clr_err when error set and clr_err coincide.
REQ-025 SHALL hold mem_rd_data stable from RESP until next RESP.

Reset
REQ-026 SHALL, on rst_n=0, immediately force state IDLE, mem_rd_valid=0, mem_rd_data=0, busy=0, err_*=0, header registers=0, counters=0.
REQ-027 SHALL NOT reset storage contents; reset mid-WAIT produces no valid pulse.

Configuration
REQ-028 SHALL, with macro VECTOR_DB_RESPONDER_STATS_EN defined, add outputs stat_beats[31:0] (increments per valid pulse, saturating) and stat_errs[15:0] (increments per misaligned/OOB beat, saturating), both reset to 0 and cleared by clr_err.
REQ-029 SHALL, without VECTOR_DB_RESPONDER_STATS_EN, omit these ports and counters entirely; all other behaviour identical.

Verification
REQ-030 Header: load_hdr with cfg = 100/0x400/0x600/0x20000; rd_en held from addr 0, initiator adds 64 per valid -> valids at T+2, T+5, T+8, T+11 with [31:0] = 100, 0x400, 0x600, 0x20000, upper bits 0.
REQ-031 Vector: write beat 10 = {16{32'hA5A5_0000 + i}}; read addr 640 -> valid 2 cycles after accept, exact pattern; same-cycle write to beat 10 during accept -> old pattern.
REQ-032 Misalign/OOB: addr 0x41 -> zero data, err_misalign=1; addr DEPTH*64 -> zero data, err_oob=1; clr_err -> both 0.
REQ-033 Abort/reset: rd_en drops cycle T+1 -> no valid, busy=0 at T+2; rst_n low during WAIT -> valid 0, header reads return 0 afterwards, storage beat 10 intact.
REQ-034 Stats: with VECTOR_DB_RESPONDER_STATS_EN, 5 good + 2 error beats -> stat_beats=7, stat_errs=2; without macro, build has no stat ports and REQ-030..033 pass.
